mant_mult_seq: RTL and testbench



---
 rtl/fpu_pkg.sv | 15 +
 rtl/rca_n.sv | 33 +++
 rtl/mant_mult_seq.sv | 105 ++++++++++
 tb/tb_mant_mult_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU datapath definitions.
//   state_t    : control-FSM encoding used by the iterative mantissa multiplier
//   SIG_W_SP/DP: significand widths (hidden bit included) for single/double
package fpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam int SIG_W_SP = 24;
   localparam int SIG_W_DP = 53;

endpackage

// File: rtl/rca_n.sv
// N-bit ripple-carry adder built as a half-adder at bit 0 followed by a
// full-adder chain.
//   a, b : N-bit addends
//   sum  : N-bit sum
//   cout : carry out of the MSB
module rca_n #(
   parameter int N = 24
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         cout
);

   // c[i] is the carry into bit i
   logic [N:1] c;

   // bit 0: half adder, no carry-in
   assign sum[0] = a[0] ^ b[0];
   assign c[1]   = a[0] & b[0];

   // bits 1..N-1: full adders
   genvar i;
   generate
      for (i = 1; i < N; i++) begin : g_fa
         assign sum[i] = a[i] ^ b[i] ^ c[i];
         assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign cout = c[N];

endmodule

// File: rtl/mant_mult_seq.sv
// Iterative radix-2 shift-and-add unsigned significand multiplier.
// One multiplier bit is consumed per RUN cycle; the full 2N-bit product is
// available N cycles after START and held until ACK.
//   CLK, RSTn : clock, asynchronous active-low reset
//   START,A,B : operand strobe and operands (taken only while READY)
//   READY     : idle, able to accept START
//   VALID,ACK : product handshake toward the normalise/round stage
//   P         : registered 2N-bit product, held until the next completion
module mant_mult_seq
   import fpu_pkg::*;
#(
   parameter int N = SIG_W_SP
) (
   input  logic         CLK,
   input  logic         RSTn,
   input  logic         START,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         READY,
   output logic         VALID,
   input  logic         ACK,
   output logic [2*N-1:0] P
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   state_t        st;
   logic          ready_q, valid_q;
   logic [N-1:0]  mcand, mplr;
   logic [N:0]    acc;
   logic [CW-1:0] cnt;

   logic [N-1:0]  addend, sum;
   logic          cout;
   logic [N:0]    acc_nx;
   logic [N-1:0]  mplr_nx;

   assign addend = mplr[0] ? mcand : '0;

   rca_n #(.N(N)) u_rca (
      .a    (acc[N-1:0]),
      .b    (addend),
      .sum  (sum),
      .cout (cout)
   );

   // {carry,sum,mplr} shifted right by one: the partial product moves down,
   // its LSB drops into the vacated top of the multiplier register.
   assign acc_nx  = {1'b0, cout, sum[N-1:1]};
   assign mplr_nx = {sum[0], mplr[N-1:1]};

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         st      <= ST_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         mcand   <= '0;
         mplr    <= '0;
         acc     <= '0;
         cnt     <= '0;
         P       <= '0;
      end else begin
         case (st)
            ST_IDLE: if (START) begin
               mcand   <= A;
               mplr    <= B;
               acc     <= '0;
               cnt     <= CW'(N-1);
               st      <= ST_RUN;
               ready_q <= 1'b0;
            end
            ST_RUN: begin
               acc  <= acc_nx;
               mplr <= mplr_nx;
               cnt  <= cnt - 1'b1;
               if (cnt == '0) begin
                  P       <= {acc_nx[N-1:0], mplr_nx};
                  st      <= ST_DONE;
                  valid_q <= 1'b1;
               end
            end
            ST_DONE: if (ACK) begin
               st      <= ST_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               st      <= ST_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign READY = ready_q;
   assign VALID = valid_q;

   // the partial product never spills past N+1 bits before the shift
   always_ff @(posedge CLK) begin
      if (RSTn && st == ST_RUN)
         assert (!acc[N]);
   end

endmodule

// File: tb/tb_mant_mult_seq.sv
module tb_mant_mult_seq;

   localparam int N = 24;

   logic           CLK = 1'b0;
   logic           RSTn = 1'b0;
   logic           START = 1'b0;
   logic [N-1:0]   A = '0;
   logic [N-1:0]   B = '0;
   logic           READY;
   logic           VALID;
   logic           ACK = 1'b0;
   logic [2*N-1:0] P;

   int checks = 0;
   int errors = 0;

   mant_mult_seq #(.N(N)) dut (
      .CLK   (CLK),
      .RSTn  (RSTn),
      .START (START),
      .A     (A),
      .B     (B),
      .READY (READY),
      .VALID (VALID),
      .ACK   (ACK),
      .P     (P)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // caller is #1 after a posedge; START is taken on the next edge
   task automatic do_start(input logic [N-1:0] a, input logic [N-1:0] b);
      A = a; B = b; START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   // counts edges after the accepting one until VALID rises (bounded)
   task automatic wait_valid(output int cyc);
      cyc = 0;
      do begin
         @(posedge CLK); #1;
         cyc++;
      end while (!VALID && cyc < 40);
   endtask

   task automatic do_ack();
      ACK = 1'b1;
      @(posedge CLK); #1;
      ACK = 1'b0;
   endtask

   initial begin
      int cyc;
      logic [N-1:0] ra, rb;
      logic [63:0]  rexp;

      // reset state
      #12;
      check("rst_ready", 64'(READY), 64'd1);
      check("rst_valid", 64'(VALID), 64'd0);
      check("rst_p",     64'(P),     64'd0);
      @(negedge CLK); RSTn = 1'b1;
      @(posedge CLK); #1;

      // 1.0 * 1.0, latency and hold without ACK
      do_start(24'h800000, 24'h800000);
      check("start_ready_low", 64'(READY), 64'd0);
      wait_valid(cyc);
      check("lat_800000", 64'(cyc), 64'd24);
      check("p_800000", 64'(P), 64'h400000000000);
      repeat (5) begin @(posedge CLK); #1; end
      check("hold_valid", 64'(VALID), 64'd1);
      check("hold_p", 64'(P), 64'h400000000000);
      do_ack();
      check("ack_ready", 64'(READY), 64'd1);
      check("ack_valid", 64'(VALID), 64'd0);

      // all ones
      do_start(24'hFFFFFF, 24'hFFFFFF);
      wait_valid(cyc);
      check("lat_ffffff", 64'(cyc), 64'd24);
      check("p_ffffff", 64'(P), 64'hFFFFFE000001);
      do_ack();
      check("ack2_ready", 64'(READY), 64'd1);

      // zero multiplicand
      do_start(24'h000000, 24'hABCDEF);
      wait_valid(cyc);
      check("p_zero", 64'(P), 64'd0);
      do_ack();

      // 0.75 * 0.75, with START pulses during RUN and DONE
      do_start(24'hC00000, 24'hC00000);
      repeat (5) begin @(posedge CLK); #1; end
      do_start(24'h123456, 24'h654321);
      check("run_start_ready", 64'(READY), 64'd0);
      wait_valid(cyc);
      check("p_c00000", 64'(P), 64'h900000000000);
      do_start(24'h111111, 24'h222222);
      check("done_start_valid", 64'(VALID), 64'd1);
      check("done_start_p", 64'(P), 64'h900000000000);
      do_ack();

      // asynchronous reset mid-run
      do_start(24'hABCDEF, 24'h123456);
      repeat (10) begin @(posedge CLK); #1; end
      #2 RSTn = 1'b0;
      #1;
      check("arst_ready", 64'(READY), 64'd1);
      check("arst_valid", 64'(VALID), 64'd0);
      check("arst_p", 64'(P), 64'd0);
      @(negedge CLK); RSTn = 1'b1;
      repeat (30) begin @(posedge CLK); #1; end
      check("arst_no_valid", 64'(VALID), 64'd0);
      do_start(24'h9ABCDE, 24'hF0F0F1);
      wait_valid(cyc);
      check("post_rst_p", 64'(P), 64'(24'h9ABCDE) * 64'(24'hF0F0F1));
      do_ack();

      // back-to-back random pairs
      for (int i = 0; i < 200; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rexp = 64'(ra) * 64'(rb);
         do_start(ra, rb);
         wait_valid(cyc);
         check("rnd_lat", 64'(cyc), 64'd24);
         check("rnd_p", 64'(P), rexp);
         do_ack();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
